// File: rtl/mp_alu_pkg.sv
// Shared types and ALU opcode constants for the multi-precision ALU sequencer.
package mp_alu_pkg;

    // Multi-byte operations accepted on the op port; codes 5-7 are reserved.
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_SHL = 3'd2,
        OP_SHR = 3'd3,
        OP_CMP = 3'd4
    } op_e;

    // Opcodes understood by the shared 8-bit combinational ALU.
    localparam logic [4:0] ALU_ADD = 5'b01101;
    localparam logic [4:0] ALU_LSL = 5'b10011;
    localparam logic [4:0] ALU_SLC = 5'b10100;
    localparam logic [4:0] ALU_LSR = 5'b10001;
    localparam logic [4:0] ALU_SRC = 5'b10010;
    localparam logic [4:0] ALU_CMP = 5'b00101;
    localparam logic [4:0] ALU_NOP = 5'b00000;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mp_alu_seq.sv
// Multi-precision sequencer: walks an operand of up to MAX_BYTES bytes through
// the shared 8-bit ALU, one byte per cycle, chaining the carry/shift bit.
module mp_alu_seq
    import mp_alu_pkg::*;
#(
    parameter int MAX_BYTES = 4,
    parameter int NB_W      = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [2:0]             op,
    input  logic [NB_W-1:0]        nbytes,
    input  logic [8*MAX_BYTES-1:0] opa,
    input  logic [8*MAX_BYTES-1:0] opb,
    output logic                   busy,
    output logic                   done,
    output logic [8*MAX_BYTES-1:0] result,
    output logic                   carry_out,
    output logic                   zero,
    output logic                   eq,
    output logic                   gt,
    output logic                   lt,
    output logic [4:0]             alu_op,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    output logic                   alu_ci,
    input  logic [7:0]             alu_rslt,
    input  logic                   alu_co,
    input  logic                   alu_eq,
    input  logic                   alu_gt,
    input  logic                   alu_lt
);

    localparam int              W      = 8 * MAX_BYTES;
    localparam int              IDX_W  = $clog2(MAX_BYTES);
    localparam logic [NB_W-1:0] MAX_NB = NB_W'(MAX_BYTES);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [W-1:0]      opa_q, opa_d, opb_q, opb_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NB_W-1:0]   cnt_q, cnt_d;
    logic              first_q, first_d;
    logic              cy_q, cy_d;
    logic [W-1:0]      result_q, result_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;
    logic              eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

    logic [NB_W-1:0]   nb_clamp, nb_m1;
    logic [7:0]        a_byte, b_byte;
    logic              descending;

    assign nb_clamp   = (nbytes > MAX_NB) ? MAX_NB : nbytes;
    assign nb_m1      = nb_clamp - NB_W'(1);
    assign descending = (op_q == OP_SHR) || (op_q == OP_CMP);
    assign a_byte     = opa_q[idx_q*8 +: 8];
    assign b_byte     = opb_q[idx_q*8 +: 8];

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign result    = result_q;
    assign carry_out = carry_q;
    assign zero      = zero_q;
    assign eq        = eq_q;
    assign gt        = gt_q;
    assign lt        = lt_q;

    // Present the current byte and carry-in to the ALU; idle the ALU outside RUN.
    always_comb begin
        alu_op = ALU_NOP;
        alu_a  = 8'h00;
        alu_b  = 8'h00;
        alu_ci = 1'b0;
        if (state_q == ST_RUN) begin
            case (op_q)
                OP_ADD: begin
                    alu_op = ALU_ADD;
                    alu_a  = a_byte;
                    alu_b  = b_byte;
                    alu_ci = first_q ? 1'b0 : cy_q;
                end
                OP_SUB: begin
                    alu_op = ALU_ADD;
                    alu_a  = a_byte;
                    alu_b  = ~b_byte;
                    alu_ci = first_q ? 1'b1 : cy_q;
                end
                OP_SHL: begin
                    alu_op = first_q ? ALU_LSL : ALU_SLC;
                    alu_a  = a_byte;
                    alu_ci = first_q ? 1'b0 : cy_q;
                end
                OP_SHR: begin
                    alu_op = first_q ? ALU_LSR : ALU_SRC;
                    alu_a  = a_byte;
                    alu_ci = first_q ? 1'b0 : cy_q;
                end
                OP_CMP: begin
                    alu_op = ALU_CMP;
                    alu_a  = a_byte;
                    alu_b  = b_byte;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic: accept in IDLE, one byte per RUN cycle, single DONE cycle.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        cy_d     = cy_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d     = op;
                    opa_d    = opa;
                    opb_d    = opb;
                    cnt_d    = nb_clamp;
                    first_d  = 1'b1;
                    cy_d     = 1'b0;
                    result_d = '0;
                    carry_d  = 1'b0;
                    zero_d   = 1'b1;
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                    eq_d     = 1'b0;
                    if ((nb_clamp == '0) || (op > OP_CMP)) begin
                        // Nothing to walk: empty operand (CMP of nothing is equal) or reserved op.
                        eq_d    = (op == OP_CMP);
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = ((op == OP_SHR) || (op == OP_CMP)) ? nb_m1[IDX_W-1:0] : '0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                first_d = 1'b0;
                cy_d    = alu_co;
                cnt_d   = cnt_q - NB_W'(1);
                idx_d   = descending ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
                if (op_q == OP_CMP) begin
                    if (!alu_eq) begin
                        // Most significant differing byte decides the ordering.
                        gt_d    = alu_gt;
                        lt_d    = alu_lt;
                        zero_d  = 1'b0;
                        state_d = ST_DONE;
                    end else if (cnt_q == NB_W'(1)) begin
                        eq_d    = 1'b1;
                        zero_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    result_d[idx_q*8 +: 8] = alu_rslt;
                    if (cnt_q == NB_W'(1)) begin
                        carry_d = alu_co;
                        zero_d  = ~|result_d;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and visible result registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            cy_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            cy_q     <= cy_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
        end
    end

    // Latched operands and opcode; only consumed while RUN, so no reset needed.
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        opa_q <= opa_d;
        opb_q <= opb_d;
    end

endmodule

// File: tb/tb_mp_alu_seq.sv
// Scoreboard bench for mp_alu_seq with a behavioural model of the shared 8-bit ALU.
module tb_mp_alu_seq;

    localparam int MB   = 4;
    localparam int NB_W = $clog2(MB + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [2:0]      op = 3'd0;
    logic [NB_W-1:0] nbytes = '0;
    logic [31:0]     opa = '0, opb = '0;
    logic            busy, done, carry_out, zero, eq, gt, lt;
    logic [31:0]     result;
    logic [4:0]      alu_op;
    logic [7:0]      alu_a, alu_b, alu_rslt;
    logic            alu_ci, alu_co, alu_eq, alu_gt, alu_lt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;

    typedef struct {
        logic [31:0] res;
        logic        cy, zr, eq, gt, lt;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    mp_alu_seq #(.MAX_BYTES(MB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .nbytes(nbytes),
        .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .zero(zero), .eq(eq), .gt(gt), .lt(lt),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
        .alu_rslt(alu_rslt), .alu_co(alu_co), .alu_eq(alu_eq),
        .alu_gt(alu_gt), .alu_lt(alu_lt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model of the parent's 8-bit ALU.
    always_comb begin
        logic [8:0] s;
        s        = 9'd0;
        alu_rslt = 8'h00;
        alu_co   = 1'b0;
        alu_eq   = 1'b0;
        alu_gt   = 1'b0;
        alu_lt   = 1'b0;
        case (alu_op)
            5'b01101: begin s = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_ci}; alu_rslt = s[7:0]; alu_co = s[8]; end
            5'b10011: begin alu_rslt = {alu_a[6:0], 1'b0};   alu_co = alu_a[7]; end
            5'b10100: begin alu_rslt = {alu_a[6:0], alu_ci}; alu_co = alu_a[7]; end
            5'b10001: begin alu_rslt = {1'b0, alu_a[7:1]};   alu_co = alu_a[0]; end
            5'b10010: begin alu_rslt = {alu_ci, alu_a[7:1]}; alu_co = alu_a[0]; end
            5'b00101: begin alu_eq = (alu_a == alu_b); alu_gt = (alu_a > alu_b); alu_lt = (alu_a < alu_b); end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole-word reference for one operation.
    function automatic exp_t model(input logic [2:0] o, input int n_in, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int n;
        logic [63:0] m, am, bm, s;
        n = (n_in > MB) ? MB : n_in;
        e.res = '0; e.cy = 1'b0; e.zr = 1'b1; e.eq = 1'b0; e.gt = 1'b0; e.lt = 1'b0;
        e.lat = n + 1; e.acc = 0;
        if (o > 3'd4 || n == 0) begin
            e.eq  = (o == 3'd4);
            e.lat = 1;
            return e;
        end
        m  = (64'd1 << (8 * n)) - 64'd1;
        am = {32'd0, a} & m;
        bm = {32'd0, b} & m;
        case (o)
            3'd0: begin s = am + bm;             e.res = s[31:0] & m[31:0]; e.cy = s[8*n]; end
            3'd1: begin s = am + (~bm & m) + 1;  e.res = s[31:0] & m[31:0]; e.cy = s[8*n]; end
            3'd2: begin s = am << 1;             e.res = s[31:0] & m[31:0]; e.cy = am[8*n-1]; end
            3'd3: begin s = am >> 1;             e.res = s[31:0];           e.cy = am[0]; end
            default: begin
                int k;
                k = 0;
                e.eq = 1'b1;
                for (int i = n - 1; i >= 0; i--) begin
                    k++;
                    if (am[8*i +: 8] != bm[8*i +: 8]) begin
                        e.eq = 1'b0;
                        e.gt = am[8*i +: 8] > bm[8*i +: 8];
                        e.lt = am[8*i +: 8] < bm[8*i +: 8];
                        break;
                    end
                end
                e.lat = k + 1;
            end
        endcase
        e.zr = (o == 3'd4) ? e.eq : (e.res == 32'd0);
        return e;
    endfunction

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || done) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("idle_timeout", 1, 0);
    endtask

    // Drive one accepted operation and push its expectation.
    task automatic do_op(input logic [2:0] o, input int n, input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        wait_idle();
        op = o; nbytes = NB_W'(n); opa = a; opb = b; start = 1'b1;
        e = model(o, n, a, b);
        e.acc = cyc;
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", result, e.res);
                    chk("carry", carry_out, e.cy);
                    chk("zero", zero, e.zr);
                    chk("eq_gt_lt", {eq, gt, lt}, {e.eq, e.gt, e.lt});
                    chk("latency", cyc - e.acc, e.lat);
                    chk("busy_cycles", busy_cnt, e.lat - 1);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_flags", {carry_out, eq, gt, lt}, 0);
        chk("rst_alu_op", alu_op, 0);

        do_op(3'd0, 2, 32'h0000_00FF, 32'h0000_0001, 1);
        do_op(3'd1, 2, 32'h0000_0100, 32'h0000_0001, 1);
        do_op(3'd1, 2, 32'h0000_0000, 32'h0000_0001, 1);
        do_op(3'd2, 4, 32'h8000_0001, 32'h0, 1);
        do_op(3'd3, 2, 32'hABCD_0001, 32'h0, 1);
        do_op(3'd4, 4, 32'h1234_5678, 32'h1233_5678, 1);
        do_op(3'd4, 4, 32'h1234_5678, 32'h1234_5678, 1);
        do_op(3'd0, 0, 32'h1234_5678, 32'h1111_1111, 1);
        do_op(3'd0, 7, 32'hFFFF_FFFF, 32'h0000_0001, 1);
        do_op(3'd4, 0, 32'h1, 32'h2, 1);
        do_op(3'd5, 3, 32'h1, 32'h2, 1);

        // Randomised mix of ops, widths and operands.
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            int n;
            o = 3'($urandom_range(0, 5));
            n = $urandom_range(0, 6);
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? (a ^ (32'h1 << $urandom_range(0, 31))) : $urandom;
            do_op(o, n, a, b, 1);
        end

        // A second start while running must be ignored.
        do_op(3'd0, 4, 32'h0102_0304, 32'h1010_1010, 1);
        op = 3'd1; nbytes = NB_W'(2); opa = 32'hFFFF_FFFF; opb = 32'h5; start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;

        // Reset during RUN aborts without a done pulse.
        do_op(3'd0, 4, 32'h1111_1111, 32'h2222_2222, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_zero", zero, 1);
        chk("abort_alu_op", alu_op, 0);
        repeat (8) @(negedge clk);

        do_op(3'd1, 3, 32'h0000_0000, 32'h0000_0000, 1);

        begin
            int t;
            t = 0;
            while ((sb.size() != 0 || busy || done) && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) chk("drain_timeout", 1, 0);
        end
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mp_alu_seq.md
Name: mp_alu_seq

Overview:
Multi-precision arithmetic sequencer that drives the shared 8-bit combinational ALU one byte per cycle, chaining carry/shift bits between bytes. It supports operands up to MAX_BYTES wide for add, subtract, shift left, shift right and compare. It sits between the core's multi-byte instruction decode and the ALU; the parent instantiates the ALU and wires it to this block's alu_* ports.

Parameters:
MAX_BYTES, 4, maximum operand width in bytes (>=2)
NB_W, $clog2(MAX_BYTES+1), width of the nbytes field

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  request; accepted only in IDLE
op  in  3  0=ADD 1=SUB 2=SHL 3=SHR 4=CMP; 5-7 reserved
nbytes  in  NB_W  active byte count; 0 is legal, values >MAX_BYTES are clamped to MAX_BYTES
opa  in  8*MAX_BYTES  operand A, little-endian bytes
opb  in  8*MAX_BYTES  operand B (ignored for shifts)
busy  out  1  high from the cycle after accept until done
done  out  1  one-cycle pulse, results valid
result  out  8*MAX_BYTES  result word; bytes >= nbytes read 0
carry_out  out  1  final carry / shifted-out bit
zero  out  1  result == 0
eq, gt, lt  out  1 each  unsigned compare flags (CMP only, else 0)
alu_op  out  5  ALU opcode
alu_a, alu_b  out  8 each  ALU operands
alu_ci  out  1  ALU carry in
alu_rslt  in  8  ALU result
alu_co, alu_eq, alu_gt, alu_lt  in  1 each  ALU flags

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE; busy, done, carry_out, eq, gt, lt = 0; result = 0; zero = 1. A reset during RUN aborts the operation with no done pulse.
- FSM states: IDLE -> RUN on start (latch opa, opb, op, clamped nbytes; clear result; idx = 0, or nbytes-1 for SHR/CMP). RUN -> DONE after the last byte. DONE -> IDLE unconditionally; done=1 only in DONE.
- nbytes=0: IDLE -> DONE directly. result=0, carry_out=0, zero=1. For CMP, eq=1.
- Reserved op: treated as nbytes=0, with eq=0.
- Rate and latency: one byte per RUN cycle. done is high at cycle T+n+1 for start accepted at T; the result register is written in the same cycle as the ALU evaluation. Outputs hold until the next accept.
- start while not in IDLE is ignored, not queued.
- Carry chain register cy, updated from alu_co each RUN cycle.
- ADD: alu_op=01101, a=A[idx], b=B[idx], ci=0 on byte 0 and cy afterwards; idx ascends.
- SUB: implemented as A+~B+1. alu_op=01101, b=~B[idx], ci=1 on byte 0 and cy afterwards. carry_out=1 means no borrow.
- SHL: ascending. Byte 0 uses 10011; later bytes use 10100 with ci=cy. carry_out = bit 7 of byte nbytes-1.
- SHR: descending from nbytes-1. The first byte uses 10001; later bytes use 10100-equivalent 10010 with ci=cy. carry_out = bit 0 of byte 0. alu_b=0 for both shifts.
- CMP: descending, alu_op=00101. On the first byte with alu_eq=0, latch gt/lt and go to DONE early (latency T+k+1, k = bytes examined). If all bytes are equal, eq=1. result=0, carry_out=0, and zero=eq.
- zero = (result over active bytes == 0), computed in DONE.
- Outside RUN: alu_op=00000, alu_a=alu_b=0, alu_ci=0.

Decomposition:
- Package mp_alu_pkg holds:
  - the op enum (ADD, SUB, SHL, SHR, CMP);
  - localparam ALU opcodes (ALU_ADD=01101, ALU_LSL=10011, ALU_SLC=10100, ALU_LSR=10001, ALU_SRC=10010, ALU_CMP=00101, ALU_NOP=00000);
  - the FSM state enum.
- No sub-module is needed; the byte mux/demux stays inline. The ALU is instantiated by the parent, not inside this block.

Test Plan (MAX_BYTES=4):
- ADD n=2, A=0x00FF, B=0x0001 -> result=0x0100, carry_out=0, zero=0, done exactly 3 cycles after the accept edge, busy high 2 cycles.
- SUB n=2, A=0x0100, B=0x0001 -> 0x00FF, carry_out=1. Then A=0x0000, B=0x0001 -> 0xFFFF, carry_out=0.
- SHL n=4, A=0x80000001 -> 0x00000002, carry_out=1. SHR n=2, A=0x0001 -> 0x0000, carry_out=1, zero=1; byte 2/3 inputs ignored.
- CMP n=4, A=0x12345678, B=0x12335678 -> gt=1, lt=0, eq=0, done at T+3 (early exit). Equal operands -> eq=1, zero=1, done at T+5.
- nbytes=0 with ADD -> done at T+1, zero=1. nbytes=7 -> clamped to 4, done at T+5.
- start pulsed during RUN -> ignored, first result unchanged. rst_n low mid-RUN -> busy=0, result=0, no done pulse, alu_op=00000 next cycle.
